wib_pwr_seq: RTL

WIB_PWR_SEQ -- requirements
Module: wib_pwr_seq

---
 rtl/wib_pwr_pkg.sv | 31 +++
 rtl/seq_timer.sv | 28 ++
 rtl/wib_pwr_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/wib_pwr_pkg.sv
// Shared constants and helpers for the WIB power sequencer.
// Holds state codes, default rail/step delays and the WIB count.
// No ports; imported by wib_pwr_seq and seq_timer.
package wib_pwr_pkg;

    localparam int NUM_WIB       = 6;
    localparam int DEF_LOCAL_DLY = 1000;
    localparam int DEF_WIB_DLY   = 10000;

    // State codes are visible in the status register, so values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UP33 = 3'd1,
        ST_UP25 = 3'd2,
        ST_RUN  = 3'd3,
        ST_DN25 = 3'd4
    } state_e;

    // Width able to hold the larger of the two delays.
    function automatic int tmr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

    // Isolate the lowest set bit (two's-complement trick).
    function automatic logic [NUM_WIB-1:0] lowest_set(input logic [NUM_WIB-1:0] v);
        return v & (-v);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with zero flag; counts down once per cycle and holds at 0.
// Latency: load takes effect on the next edge; zero is combinational from the count.
// Ports: clk, rstn (sync active-low), load/load_val, zero.
module seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/wib_pwr_seq.sv
// WIB power sequencer: brings up local 3V3 then 2V5, then turns on requested WIBs
// one at a time WIB_DLY cycles apart; turn-offs are immediate, rails fall in reverse.
// Ports: clk_axi, rstn_axi (sync active-low), wib_req_in mask, kill_in; all outputs registered.
module wib_pwr_seq
    import wib_pwr_pkg::*;
#(
    parameter int LOCAL_DLY = DEF_LOCAL_DLY,
    parameter int WIB_DLY   = DEF_WIB_DLY
) (
    input  logic       clk_axi,
    input  logic       rstn_axi,
    input  logic [5:0] wib_req_in,
    input  logic       kill_in,
    output logic [5:0] wib_en_out,
    output logic [5:0] wib_on_led_out,
    output logic       local_3v3_en_out,
    output logic       local_2v5_en_out,
    output logic       busy_out,
    output logic [2:0] state_out
);

    localparam int TW = tmr_width(LOCAL_DLY, WIB_DLY);
    localparam logic [TW-1:0] LOCAL_RLD = TW'(LOCAL_DLY - 1);
    localparam logic [TW-1:0] WIB_RLD   = TW'(WIB_DLY - 1);

    state_e               state, state_nxt;
    logic [NUM_WIB-1:0]   wib_en, wib_en_nxt;
    logic                 v33, v33_nxt;
    logic                 v25, v25_nxt;
    logic                 busy, busy_nxt;
    logic [NUM_WIB-1:0]   pending;
    logic                 tmr_load;
    logic [TW-1:0]        tmr_val;
    logic                 tmr_zero;

    // One timer serves both rail spacing and WIB step spacing; the phases never overlap.
    seq_timer #(.W(TW)) u_timer (
        .clk      (clk_axi),
        .rstn     (rstn_axi),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk_axi) begin
        if (!rstn_axi) begin
            state  <= ST_IDLE;
            wib_en <= '0;
            v33    <= 1'b0;
            v25    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            wib_en <= wib_en_nxt;
            v33    <= v33_nxt;
            v25    <= v25_nxt;
            busy   <= busy_nxt;
        end
    end

    assign pending = wib_req_in & ~wib_en;

    always_comb begin
        state_nxt  = state;
        wib_en_nxt = wib_en;
        v33_nxt    = v33;
        v25_nxt    = v25;
        busy_nxt   = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        if (kill_in) begin
            // Emergency off: drop everything at once, park the timer at 0.
            state_nxt  = ST_IDLE;
            wib_en_nxt = '0;
            v33_nxt    = 1'b0;
            v25_nxt    = 1'b0;
            tmr_load   = 1'b1;
            tmr_val    = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wib_req_in != '0) begin
                        state_nxt = ST_UP33;
                        v33_nxt   = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = LOCAL_RLD;
                    end
                end
                ST_UP33: begin
                    if (tmr_zero) begin
                        state_nxt = ST_UP25;
                        v25_nxt   = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = LOCAL_RLD;
                    end
                end
                ST_UP25: begin
                    // Timer is at 0 on exit, so the first WIB step is immediately allowed.
                    if (tmr_zero) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if ((wib_req_in == '0) && (wib_en == '0)) begin
                        state_nxt = ST_DN25;
                        v25_nxt   = 1'b0;
                        tmr_load  = 1'b1;
                        tmr_val   = LOCAL_RLD;
                    end else begin
                        // Drops are immediate; at most one new WIB per step interval.
                        wib_en_nxt = wib_en & wib_req_in;
                        if ((pending != '0) && tmr_zero) begin
                            wib_en_nxt = wib_en_nxt | lowest_set(pending);
                            tmr_load   = 1'b1;
                            tmr_val    = WIB_RLD;
                        end
                    end
                end
                ST_DN25: begin
                    if (tmr_zero) begin
                        state_nxt = ST_IDLE;
                        v33_nxt   = 1'b0;
                    end
                end
                default: begin
                    state_nxt  = ST_IDLE;
                    wib_en_nxt = '0;
                    v33_nxt    = 1'b0;
                    v25_nxt    = 1'b0;
                end
            endcase
        end

        // Busy is registered, so it is derived from the next-cycle values.
        case (state_nxt)
            ST_UP33, ST_UP25, ST_DN25: busy_nxt = 1'b1;
            ST_RUN:                    busy_nxt = |(wib_req_in & ~wib_en_nxt);
            default:                   busy_nxt = 1'b0;
        endcase
    end

    assign wib_en_out       = wib_en;
    assign wib_on_led_out   = wib_en;
    assign local_3v3_en_out = v33;
    assign local_2v5_en_out = v25;
    assign busy_out         = busy;
    assign state_out        = state;

endmodule
